// File: rtl/page_walker_if.sv
// rtl/page_walker_if.sv - walk request, PTE read port and TLB fill bundle of the page walker
interface page_walker_if #(
    parameter int SADDR = 64,
    parameter int SPCID = 12
);
    logic             walk_req;
    logic [SADDR-1:0] walk_va;
    logic [SPCID-1:0] walk_pcid;
    logic [SADDR-1:0] root;
    logic             walk_busy;
    logic             mem_req;
    logic [SADDR-1:0] mem_addr;
    logic             mem_ack;
    logic [63:0]      mem_rdata;
    logic             insert;
    logic [SADDR-1:0] va;
    logic [SADDR-1:0] pa;
    logic [SPCID-1:0] pcid;
    logic             fault;
    logic [2:0]       fault_level;

    // master is the walker itself, slave is the TLB/memory side around it
    modport master (
        input  walk_req, walk_va, walk_pcid, root, mem_ack, mem_rdata,
        output walk_busy, mem_req, mem_addr, insert, va, pa, pcid, fault, fault_level
    );
    modport slave (
        output walk_req, walk_va, walk_pcid, root, mem_ack, mem_rdata,
        input  walk_busy, mem_req, mem_addr, insert, va, pa, pcid, fault, fault_level
    );
endinterface

// File: rtl/page_walker.sv
// rtl/page_walker.sv - radix page-table walker filling the TLB; PAGE_WALKER_HUGE_EN enables 2 MiB/1 GiB leaves
module page_walker #(
    parameter int SADDR  = 64,
    parameter int SPAGE  = 12,
    parameter int SPCID  = 12,
    parameter int LEVELS = 4
) (
    input  logic          clk,
    input  logic          rst,
    page_walker_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, FAULT} state_t;

    state_t                 state, next_state;
    logic [2:0]             lvl;
    logic [SADDR-SPAGE-1:0] base_ppn;
    logic [SADDR-1:0]       va_shift;
    logic [SADDR-1:0]       off_mask;
    logic [SADDR-1:0]       pte_base;
    logic [8:0]             idx;
    logic                   pte_valid;
    logic                   huge;
    logic                   leaf;
    logic                   unused_bits;

    assign va_shift  = bus.va >> (SPAGE + 9 * int'(lvl));
    assign idx       = va_shift[8:0];
    // offset bits of a leaf at the current level: 12 at level 0, 21 at level 1, 30 at level 2
    assign off_mask  = ~({SADDR{1'b1}} << (SPAGE + 9 * int'(lvl)));
    assign pte_base  = {bus.mem_rdata[SADDR-1:SPAGE], {SPAGE{1'b0}}};
    assign pte_valid = bus.mem_rdata[0];

`ifdef PAGE_WALKER_HUGE_EN
    assign huge = bus.mem_rdata[7] && (lvl == 3'd1 || lvl == 3'd2) && (lvl != 3'(LEVELS - 1));
`else
    assign huge = 1'b0;
`endif

    assign leaf        = (lvl == 3'd0) || huge;
    assign unused_bits = ^{bus.mem_rdata, va_shift, bus.root[SPAGE-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (bus.walk_req) next_state = ISSUE;
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (bus.mem_ack) begin
                    if (!pte_valid)  next_state = FAULT;
                    else if (leaf)   next_state = DONE;
                    else             next_state = ISSUE;
                end
            end
            DONE:    next_state = IDLE;
            FAULT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign bus.walk_busy = (state != IDLE);
    assign bus.mem_req   = (state == WAIT);
    assign bus.insert    = (state == DONE);
    assign bus.fault     = (state == FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl             <= '0;
            base_ppn        <= '0;
            bus.mem_addr    <= '0;
            bus.va          <= '0;
            bus.pa          <= '0;
            bus.pcid        <= '0;
            bus.fault_level <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.walk_req) begin
                        bus.va   <= bus.walk_va;
                        bus.pcid <= bus.walk_pcid;
                        base_ppn <= bus.root[SADDR-1:SPAGE];
                        lvl      <= 3'(LEVELS - 1);
                    end
                end
                ISSUE: bus.mem_addr <= {base_ppn, idx, 3'b000};
                WAIT: begin
                    if (bus.mem_ack) begin
                        if (!pte_valid) begin
                            bus.fault_level <= lvl;
                        end else if (leaf) begin
                            bus.pa <= (pte_base & ~off_mask) | (bus.va & off_mask);
                        end else begin
                            base_ppn <= bus.mem_rdata[SADDR-1:SPAGE];
                            lvl      <= lvl - 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_page_walker.sv
// tb/tb_page_walker.sv - scoreboard bench for page_walker with a table-driven PTE memory
module tb_page_walker;
    localparam int SADDR  = 64;
    localparam int SPCID  = 12;
    localparam int LEVELS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    page_walker_if #(.SADDR(SADDR), .SPCID(SPCID)) bus ();

    page_walker #(.SADDR(SADDR), .SPAGE(12), .SPCID(SPCID), .LEVELS(LEVELS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_fault;
        logic [63:0] pa;
        logic [63:0] va;
        logic [11:0] pcid;
        logic [2:0]  lvl;
        int          cycles;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           accept_cyc = 0;
    int           mem_wait = 0;
    bit           mem_en = 1'b0;
    bit           aborted = 1'b0;
    exp_t         sb[$];
    logic [63:0]  addr_q[$];
    logic [63:0]  mem[logic [63:0]];

    localparam logic [63:0] VA1 = 64'h0000_7F12_3456_7ABC;
    localparam logic [63:0] VA2 = 64'h0000_7F00_0000_0000;
    localparam logic [63:0] VA5 = 64'h0000_0000_1234_5678;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pte_addr(input logic [63:0] base, input logic [63:0] v, input int l);
        return base + (((v >> (12 + 9 * l)) & 64'h1FF) << 3);
    endfunction

    // PTE memory: answers each request after mem_wait extra cycles
    initial begin
        logic [63:0] a;
        forever begin
            @(posedge clk); #1;
            if (mem_en && bus.mem_req) begin
                a = bus.mem_addr;
                if (addr_q.size() == 0) check("unexpected_read", a, 64'h0);
                else                    check("mem_addr", a, addr_q.pop_front());
                repeat (mem_wait) begin
                    @(posedge clk); #1;
                    if (!aborted) begin
                        check("req_hold", bus.mem_req, 1);
                        check("addr_hold", bus.mem_addr, a);
                    end
                end
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem.exists(a) ? mem[a] : 64'h0;
                @(posedge clk); #1;
                bus.mem_ack   = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (bus.insert || bus.fault) begin
                if (sb.size() == 0) begin
                    check("spurious_strobe", {bus.insert, bus.fault}, 0);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind", bus.fault, e.is_fault);
                    check("strobe_one", bus.insert ^ bus.fault, 1);
                    check("pa", bus.pa, e.pa);
                    check("va", bus.va, e.va);
                    check("pcid", bus.pcid, e.pcid);
                    check("latency", cyc - accept_cyc + 1, e.cycles);
                    if (e.is_fault) check("fault_level", bus.fault_level, e.lvl);
                    @(posedge clk); #1;
                    check("busy_fall", bus.walk_busy, 0);
                    check("strobe_width", bus.insert | bus.fault, 0);
                    check("va_held", bus.va, e.va);
                end
            end
        end
    end

    task automatic start_walk(input logic [63:0] v, input logic [11:0] p, input logic [63:0] r);
        int n = 0;
        while (bus.walk_busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_before_req", bus.walk_busy, 0);
        bus.walk_va   = v;
        bus.walk_pcid = p;
        bus.root      = r;
        bus.walk_req  = 1'b1;
        @(posedge clk); #1;
        accept_cyc   = cyc;
        bus.walk_req = 1'b0;
        check("busy_after_accept", bus.walk_busy, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || bus.walk_busy) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("walk_timeout", n < 300, 1);
        check("reads_left", addr_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.walk_req  = 1'b0;
        bus.walk_va   = '0;
        bus.walk_pcid = '0;
        bus.root      = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        mem[64'h17F0]                   = 64'h2001;
        mem[pte_addr(64'h2000, VA1, 2)] = 64'h3001;
        mem[pte_addr(64'h3000, VA1, 1)] = 64'h4001;
        mem[pte_addr(64'h4000, VA1, 0)] = 64'h0000_0000_ABCD_E001;
        mem[64'h5000]                   = 64'h6081;
        mem[64'h6000]                   = 64'h7001;
        mem[64'h7488]                   = 64'h0000_0000_4020_0081;
        mem[64'h4020_0A28]              = 64'h0000_0000_9999_9001;

        #1;
        check("rst_busy", bus.walk_busy, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_insert", bus.insert, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_va", bus.va, 0);
        check("rst_pa", bus.pa, 0);
        check("rst_pcid", bus.pcid, 0);
        check("rst_fault_level", bus.fault_level, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mem_en = 1'b1;

        // full 4-level walk, zero-wait memory
        addr_q.push_back(64'h17F0);
        addr_q.push_back(pte_addr(64'h2000, VA1, 2));
        addr_q.push_back(pte_addr(64'h3000, VA1, 1));
        addr_q.push_back(pte_addr(64'h4000, VA1, 0));
        sb.push_back('{1'b0, 64'hABCD_EABC, VA1, 12'h05A, 3'd0, 9});
        start_walk(VA1, 12'h05A, 64'h1000);
        wait_done();

        // invalid PTE on the second read
        addr_q.push_back(64'h17F0);
        addr_q.push_back(64'h2000);
        sb.push_back('{1'b1, 64'hABCD_EABC, VA2, 12'h123, 3'd2, 5});
        start_walk(VA2, 12'h123, 64'h1ABC);
        wait_done();

        // three wait cycles on every read
        mem_wait = 3;
        addr_q.push_back(64'h17F0);
        addr_q.push_back(pte_addr(64'h2000, VA1, 2));
        addr_q.push_back(pte_addr(64'h3000, VA1, 1));
        addr_q.push_back(pte_addr(64'h4000, VA1, 0));
        sb.push_back('{1'b0, 64'hABCD_EABC, VA1, 12'h777, 3'd0, 21});
        start_walk(VA1, 12'h777, 64'h1000);
        wait_done();

        // busy rejection, then reset mid-walk with a late ack
        mem_wait = 4;
        addr_q.push_back(64'h17F0);
        start_walk(VA1, 12'h0AA, 64'h1000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.walk_va  = 64'hDEAD_0000;
        bus.walk_req = 1'b1;
        @(posedge clk); #1;
        bus.walk_req = 1'b0;
        check("busy_ignore_va", bus.va, VA1);
        check("busy_ignore_busy", bus.walk_busy, 1);
        check("busy_ignore_req", bus.mem_req, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        aborted = 1'b1;
        #1;
        check("abort_mem_req", bus.mem_req, 0);
        check("abort_busy", bus.walk_busy, 0);
        check("abort_va", bus.va, 0);
        check("abort_pa", bus.pa, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_insert", bus.insert, 0);
            check("abort_idle", bus.walk_busy, 0);
        end
        aborted  = 1'b0;
        mem_wait = 0;

        // level-1 PS leaf; PS on the root entry is always ignored
        addr_q.push_back(64'h5000);
        addr_q.push_back(64'h6000);
        addr_q.push_back(64'h7488);
`ifdef PAGE_WALKER_HUGE_EN
        sb.push_back('{1'b0, 64'h4034_5678, VA5, 12'hFFF, 3'd0, 7});
`else
        addr_q.push_back(64'h4020_0A28);
        sb.push_back('{1'b0, 64'h9999_9678, VA5, 12'hFFF, 3'd0, 9});
`endif
        start_walk(VA5, 12'hFFF, 64'h5000);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
